uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver, 8N1 framing (1 start, 8 data LSB-first, 1 stop).
- Sits downstream of the UART transmitter on the serial link. Consumes the line and presents each received byte to fabric logic with a one-cycle valid strobe.
- Each bit is sampled once at mid-bit. The receiver flags framing errors and rejects glitches on the start bit.

---
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, start-glitch
// rejection, framing-error pulse and break hold-off until the line idles high.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          rx_m_q;
  logic          rx_s_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= i_rx;
      rx_s_q <= rx_m_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit; a high level here was a glitch.
          if (cnt_q != HALF) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (!rx_s_q) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not be decoded as further frames.
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three instances (C=4, 8, 104), table-driven frames
// plus hand-written reset, glitch and break sequences, scoreboard-checked.
module tb_uart_receiver;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         due;
  } exp_t;

  typedef struct {
    int         dut;
    logic [7:0] b;
    logic       stop;
    int         per;
    int         idle;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx   [3];
  logic [7:0] dat  [3];
  logic       vld  [3];
  logic       fe   [3];
  logic       bsy  [3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int cpb [3] = '{4, 8, 104};

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t vecs[7];

  uart_receiver #(.CLKS_PER_BIT(4)) u_c4 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .o_data(dat[0]),
    .o_valid(vld[0]), .o_frame_err(fe[0]), .o_busy(bsy[0]));
  uart_receiver #(.CLKS_PER_BIT(8)) u_c8 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .o_data(dat[1]),
    .o_valid(vld[1]), .o_frame_err(fe[1]), .o_busy(bsy[1]));
  uart_receiver #(.CLKS_PER_BIT(104)) u_c104 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx[2]), .o_data(dat[2]),
    .o_valid(vld[2]), .o_frame_err(fe[2]), .o_busy(bsy[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Expected pulse: edge 0 is the posedge after this negedge, pulse is seen
  // at the negedge following edge 3+H+9C.
  task automatic expect_pulse(input int d, input logic err, input logic [7:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    e.due  = cyc + 1 + 3 + (cpb[d] - 1) / 2 + 9 * cpb[d];
    push_exp(d, e);
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic stop, input int per);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx[d] = fr[i];
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (vld[d] || fe[d]) begin
      check($sformatf("excl_d%0d", d), int'(vld[d] && fe[d]), 0);
      if (qsize(d) == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse_d%0d valid=%0b ferr=%0b data=0x%0h expected no pulse (cycle %0d)",
                 d, vld[d], fe[d], dat[d], cyc);
      end else begin
        e = pop_exp(d);
        check($sformatf("kind_d%0d", d), int'(fe[d]), int'(e.err));
        check($sformatf("due_d%0d", d), cyc, e.due);
        check($sformatf("data_d%0d", d), int'(dat[d]), int'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) mon(d);
    end
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b1, 4,   10,  1'b0, 8'hA5};
    vecs[1] = '{0, 8'h00, 1'b1, 4,   0,   1'b0, 8'h00};
    vecs[2] = '{0, 8'hFF, 1'b1, 4,   0,   1'b0, 8'hFF};
    vecs[3] = '{0, 8'h81, 1'b1, 4,   20,  1'b0, 8'h81};
    vecs[4] = '{1, 8'h9E, 1'b1, 8,   20,  1'b0, 8'h9E};
    vecs[5] = '{2, 8'hC3, 1'b1, 108, 300, 1'b0, 8'hC3};
    vecs[6] = '{2, 8'hC3, 1'b1, 100, 300, 1'b0, 8'hC3};

    for (int d = 0; d < 3; d++) rx[d] = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_busy_d%0d", d), int'(bsy[d]), 0);
      check($sformatf("rst_data_d%0d", d), int'(dat[d]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame's data bits
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_busy", int'(bsy[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", int'(bsy[0]), 0);
    check("arst_valid", int'(vld[0]), 0);
    check("arst_ferr", int'(fe[0]), 0);
    check("arst_data", int'(dat[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    expect_pulse(0, 1'b0, 8'h3C);
    send(0, 8'h3C, 1'b1, 4);
    rx[0] = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      expect_pulse(vecs[i].dut, vecs[i].exp_err, vecs[i].exp_data);
      send(vecs[i].dut, vecs[i].b, vecs[i].stop, vecs[i].per);
      rx[vecs[i].dut] = 1'b1;
      repeat (vecs[i].idle) @(negedge clk);
    end

    // Start-bit glitch on the C=8 receiver
    rx[1] = 1'b0;
    @(negedge clk);
    rx[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", int'(bsy[1]), 1);
    repeat (20) @(negedge clk);
    check("glitch_idle", int'(bsy[1]), 0);
    check("glitch_data", int'(dat[1]), 8'h9E);

    // Framing error followed by a 30-bit-time break
    expect_pulse(1, 1'b1, 8'h9E);
    send(1, 8'h55, 1'b0, 8);
    repeat (30 * 8) @(negedge clk);
    check("break_busy", int'(bsy[1]), 1);
    check("break_data", int'(dat[1]), 8'h9E);
    rx[1] = 1'b1;
    repeat (20) @(negedge clk);
    check("break_idle", int'(bsy[1]), 0);
    expect_pulse(1, 1'b0, 8'h12);
    send(1, 8'h12, 1'b1, 8);
    rx[1] = 1'b1;

    for (int k = 0; k < 3000 && (qsize(0) + qsize(1) + qsize(2)) > 0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("pending_d%0d", d), qsize(d), 0);
    check("final_data_d0", int'(dat[0]), 8'h81);
    check("final_data_d1", int'(dat[1]), 8'h12);
    check("final_data_d2", int'(dat[2]), 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
